// File: rtl/polara_loopback_pkg.sv
// Shared header layout, enable encoding and payload patterns for the polara loopback
// generator/checker pair, so both ends derive the same expected stream.
package polara_loopback_pkg;

  localparam int LEN_HI = 29;
  localparam int LEN_LO = 22;

  localparam logic [1:0] EN_NONE = 2'b00;
  localparam logic [1:0] EN_NOC1 = 2'b01;
  localparam logic [1:0] EN_NOC2 = 2'b10;
  localparam logic [1:0] EN_ALL  = 2'b11;

  typedef enum logic {
    HDR = 1'b0,
    PLD = 1'b1
  } chk_state_e;

  function automatic logic [63:0] walk_pattern(input logic [5:0] k);
    return 64'h1 << k;
  endfunction

  function automatic logic [63:0] seq_pattern(input logic [31:0] seq);
    return {seq, ~seq};
  endfunction

endpackage

// File: rtl/polara_loopback_chan_checker.sv
// One NoC channel: header/payload FSM, running sequence counter, packet and error counters.
// Errors leave as a one-cycle pulse (plus offending data) registered one cycle after the accept.
module polara_loopback_chan_checker
  import polara_loopback_pkg::*;
#(
  parameter int MAX_PAYLOAD = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             acc_i,
  input  logic             march_i,
  input  logic [63:0]      dat_i,
  output logic [CNT_W-1:0] pkt_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             err_o,
  output logic [63:0]      err_dat_o
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  chk_state_e       state_q;
  logic [7:0]       len_q, k_q;
  logic             pm_q;
  logic [31:0]      seq_q;
  logic [CNT_W-1:0] pkt_cnt_q, err_cnt_q, err_cnt_d;
  logic             err_q;
  logic [63:0]      err_dat_q;

  logic [7:0]  hdr_len;
  logic        hdr_ok;
  logic [63:0] exp_dat;

  assign hdr_len   = dat_i[LEN_HI:LEN_LO];
  assign hdr_ok    = (hdr_len != 8'd0) && (hdr_len <= MAX_LEN);
  assign exp_dat   = pm_q ? walk_pattern(k_q[5:0]) : seq_pattern(seq_q);
  assign err_cnt_d = (err_q && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= HDR;
      len_q     <= '0;
      k_q       <= '0;
      pm_q      <= 1'b0;
      seq_q     <= '0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
      err_q     <= 1'b0;
      err_dat_q <= '0;
    end else begin
      err_q     <= 1'b0;
      err_cnt_q <= err_cnt_d;
      if (acc_i) begin
        case (state_q)
          HDR: begin
            len_q <= hdr_len;
            pm_q  <= march_i;
            k_q   <= '0;
            if (hdr_ok) begin
              state_q <= PLD;
            end else begin
              // Illegal length: the header alone is the whole (failed) packet.
              pkt_cnt_q <= pkt_cnt_q + 1'b1;
              err_q     <= 1'b1;
              err_dat_q <= dat_i;
            end
          end
          PLD: begin
            k_q   <= k_q + 8'd1;
            seq_q <= seq_q + 32'd1;
            if (dat_i != exp_dat) begin
              err_q     <= 1'b1;
              err_dat_q <= dat_i;
            end
            if (k_q == len_q - 8'd1) begin
              pkt_cnt_q <= pkt_cnt_q + 1'b1;
              state_q   <= HDR;
            end
          end
          default: state_q <= HDR;
        endcase
      end
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
  assign err_cnt_o = err_cnt_q;
  assign err_o     = err_q;
  assign err_dat_o = err_dat_q;

endmodule

// File: rtl/polara_loopback_packet_checker.sv
// Checks packets looped back on NoC1/2/3 against the generator pattern; three channel
// checkers plus enable decode, registered ready, sticky fail flag and first-error capture.
module polara_loopback_packet_checker
  import polara_loopback_pkg::*;
#(
  parameter int MAX_PAYLOAD = 8,
  parameter int CNT_W       = 16
) (
  input  logic             chipset_clk,
  input  logic             chip_rst,
  input  logic [1:0]       sw_debounced,
  input  logic             march,
  input  logic [63:0]      intf_chipset_data_noc1,
  input  logic [63:0]      intf_chipset_data_noc2,
  input  logic [63:0]      intf_chipset_data_noc3,
  input  logic             intf_chipset_val_noc1,
  input  logic             intf_chipset_val_noc2,
  input  logic             intf_chipset_val_noc3,
  output logic             intf_chipset_rdy_noc1,
  output logic             intf_chipset_rdy_noc2,
  output logic             intf_chipset_rdy_noc3,
  output logic [CNT_W-1:0] pkt_cnt_noc1,
  output logic [CNT_W-1:0] pkt_cnt_noc2,
  output logic [CNT_W-1:0] pkt_cnt_noc3,
  output logic [CNT_W-1:0] err_cnt_noc1,
  output logic [CNT_W-1:0] err_cnt_noc2,
  output logic [CNT_W-1:0] err_cnt_noc3,
  output logic             check_fail,
  output logic [63:0]      first_err_data
);

  logic [2:0]             en, rdy_q, acc, err;
  logic [2:0][63:0]       dat, err_dat;
  logic [2:0][CNT_W-1:0]  pkt_cnt, err_cnt;
  logic                   check_fail_q;
  logic [63:0]            first_err_q, first_err_d;

  always_comb begin
    en = 3'b000;
    case (sw_debounced)
      EN_NONE: en = 3'b000;
      EN_NOC1: en = 3'b001;
      EN_NOC2: en = 3'b010;
      EN_ALL:  en = 3'b111;
      default: en = 3'b000;
    endcase
  end

  assign dat = {intf_chipset_data_noc3, intf_chipset_data_noc2, intf_chipset_data_noc1};
  assign acc = {intf_chipset_val_noc3, intf_chipset_val_noc2, intf_chipset_val_noc1} & rdy_q;

  for (genvar i = 0; i < 3; i++) begin : g_chan
    polara_loopback_chan_checker #(
      .MAX_PAYLOAD(MAX_PAYLOAD),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk_i    (chipset_clk),
      .rst_i    (chip_rst),
      .acc_i    (acc[i]),
      .march_i  (march),
      .dat_i    (dat[i]),
      .pkt_cnt_o(pkt_cnt[i]),
      .err_cnt_o(err_cnt[i]),
      .err_o    (err[i]),
      .err_dat_o(err_dat[i])
    );
  end

  // Lowest-numbered NoC wins when several channels fail in the same cycle.
  always_comb begin
    first_err_d = first_err_q;
    if (!check_fail_q) begin
      if (err[0])      first_err_d = err_dat[0];
      else if (err[1]) first_err_d = err_dat[1];
      else if (err[2]) first_err_d = err_dat[2];
    end
  end

  always_ff @(posedge chipset_clk) begin
    if (chip_rst) begin
      rdy_q        <= '0;
      check_fail_q <= 1'b0;
      first_err_q  <= '0;
    end else begin
      rdy_q        <= en;
      check_fail_q <= check_fail_q | (|err);
      first_err_q  <= first_err_d;
    end
  end

  assign intf_chipset_rdy_noc1 = rdy_q[0];
  assign intf_chipset_rdy_noc2 = rdy_q[1];
  assign intf_chipset_rdy_noc3 = rdy_q[2];
  assign pkt_cnt_noc1          = pkt_cnt[0];
  assign pkt_cnt_noc2          = pkt_cnt[1];
  assign pkt_cnt_noc3          = pkt_cnt[2];
  assign err_cnt_noc1          = err_cnt[0];
  assign err_cnt_noc2          = err_cnt[1];
  assign err_cnt_noc3          = err_cnt[2];
  assign check_fail            = check_fail_q;
  assign first_err_data        = first_err_q;

endmodule

// File: tb/tb_polara_loopback_packet_checker.sv
// Directed bench for the loopback packet checker; expected values are hand-derived.
module tb_polara_loopback_packet_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sw;
  logic        march;
  logic [63:0] dat [3];
  logic [2:0]  val;
  logic        rdy1, rdy2, rdy3;
  logic [15:0] pkt1, pkt2, pkt3, err1, err2, err3;
  logic        fail;
  logic [63:0] first;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  polara_loopback_packet_checker dut (
    .chipset_clk           (clk),
    .chip_rst              (rst),
    .sw_debounced          (sw),
    .march                 (march),
    .intf_chipset_data_noc1(dat[0]),
    .intf_chipset_data_noc2(dat[1]),
    .intf_chipset_data_noc3(dat[2]),
    .intf_chipset_val_noc1 (val[0]),
    .intf_chipset_val_noc2 (val[1]),
    .intf_chipset_val_noc3 (val[2]),
    .intf_chipset_rdy_noc1 (rdy1),
    .intf_chipset_rdy_noc2 (rdy2),
    .intf_chipset_rdy_noc3 (rdy3),
    .pkt_cnt_noc1          (pkt1),
    .pkt_cnt_noc2          (pkt2),
    .pkt_cnt_noc3          (pkt3),
    .err_cnt_noc1          (err1),
    .err_cnt_noc2          (err2),
    .err_cnt_noc3          (err3),
    .check_fail            (fail),
    .first_err_data        (first)
  );

  function automatic logic [63:0] hdr(input int len);
    logic [63:0] h;
    h = '0;
    h[29:22] = 8'(len);
    return h;
  endfunction

  function automatic logic [63:0] sp(input int s);
    logic [31:0] v;
    v = 32'(s);
    return {v, ~v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input logic [63:0] d);
    dat[ch] = d;
    val[ch] = 1'b1;
    tick();
    val[ch] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sw = 2'b01; march = 1'b0; val = 3'b111;
    for (int i = 0; i < 3; i++) dat[i] = hdr(1);
    repeat (3) tick();
    checks++; if ({rdy1, rdy2, rdy3} !== 3'b000) begin errors++; $display("FAIL reset_rdy got %b want 000", {rdy1, rdy2, rdy3}); end
    checks++; if ({pkt1, pkt2, pkt3} !== 48'd0) begin errors++; $display("FAIL reset_pkt got %h want 0", {pkt1, pkt2, pkt3}); end
    checks++; if ({err1, err2, err3} !== 48'd0) begin errors++; $display("FAIL reset_err got %h want 0", {err1, err2, err3}); end
    checks++; if (fail !== 1'b0 || first !== 64'd0) begin errors++; $display("FAIL reset_fail got %b/%h want 0/0", fail, first); end
    rst = 1'b0; val = 3'b000;
    tick();
    checks++; if ({rdy1, rdy2, rdy3} !== 3'b100) begin errors++; $display("FAIL release_rdy got %b want 100", {rdy1, rdy2, rdy3}); end
  endtask

  task automatic test_sequence();
    march = 1'b0;
    send(0, hdr(2)); send(0, sp(0)); tick(); send(0, sp(1));
    checks++; if (pkt1 !== 16'd1) begin errors++; $display("FAIL seq_pkt got %0d want 1", pkt1); end
    tick(); tick();
    checks++; if (err1 !== 16'd0 || fail !== 1'b0) begin errors++; $display("FAIL seq_err got %0d/%b want 0/0", err1, fail); end
    send(0, hdr(1)); send(0, sp(2)); tick(); tick();
    checks++; if (pkt1 !== 16'd2 || err1 !== 16'd0) begin errors++; $display("FAIL seq_next got %0d/%0d want 2/0", pkt1, err1); end
  endtask

  task automatic test_march();
    march = 1'b1;
    send(0, hdr(3));
    march = 1'b0;  // latched mode must hold for the packet
    send(0, 64'd1); send(0, 64'd2); send(0, 64'd4); tick(); tick();
    checks++; if (pkt1 !== 16'd3 || err1 !== 16'd0) begin errors++; $display("FAIL march_pass got %0d/%0d want 3/0", pkt1, err1); end
    march = 1'b1;
    send(0, hdr(3)); send(0, 64'd1); send(0, 64'd2); send(0, 64'd3);
    checks++; if (pkt1 !== 16'd4 || fail !== 1'b0 || err1 !== 16'd0) begin errors++; $display("FAIL march_lat0 got %0d/%b/%0d want 4/0/0", pkt1, fail, err1); end
    tick();
    checks++; if (err1 !== 16'd1 || fail !== 1'b1) begin errors++; $display("FAIL march_err got %0d/%b want 1/1", err1, fail); end
    checks++; if (first !== 64'd3) begin errors++; $display("FAIL march_first got %h want 3", first); end
  endtask

  task automatic test_bad_header();
    march = 1'b0;
    send(0, hdr(0)); send(0, hdr(9)); tick(); tick();
    checks++; if (err1 !== 16'd3 || pkt1 !== 16'd6) begin errors++; $display("FAIL badhdr got %0d/%0d want 3/6", err1, pkt1); end
    send(0, hdr(1) | 64'hFFFF_FFFF_C03F_FFFF); send(0, sp(9)); tick(); tick();
    checks++; if (err1 !== 16'd3 || pkt1 !== 16'd7) begin errors++; $display("FAIL after_bad got %0d/%0d want 3/7", err1, pkt1); end
    checks++; if (first !== 64'd3) begin errors++; $display("FAIL first_sticky got %h want 3", first); end
    march = 1'b1;
    send(0, hdr(8));
    for (int k = 0; k < 8; k++) send(0, 64'd1 << k);
    tick(); tick();
    checks++; if (err1 !== 16'd3 || pkt1 !== 16'd8) begin errors++; $display("FAIL maxlen got %0d/%0d want 3/8", err1, pkt1); end
  endtask

  task automatic test_enable();
    march = 1'b0;
    dat[1] = hdr(1); val[1] = 1'b1; tick(); tick(); val[1] = 1'b0;
    checks++; if (rdy2 !== 1'b0 || pkt2 !== 16'd0 || err2 !== 16'd0) begin errors++; $display("FAIL dis_noc2 got %b/%0d/%0d want 0/0/0", rdy2, pkt2, err2); end
    send(0, hdr(2)); send(0, sp(18));
    sw = 2'b11;
    checks++; if ({rdy2, rdy3} !== 2'b00) begin errors++; $display("FAIL en_late got %b want 00", {rdy2, rdy3}); end
    tick();
    checks++; if ({rdy1, rdy2, rdy3} !== 3'b111) begin errors++; $display("FAIL en_all got %b want 111", {rdy1, rdy2, rdy3}); end
    dat[0] = sp(19); dat[1] = hdr(1); dat[2] = hdr(1); val = 3'b111; tick();
    dat[1] = sp(0); dat[2] = sp(0); val = 3'b110; tick();
    val = 3'b000; tick(); tick();
    checks++; if ({pkt1, pkt2, pkt3} !== {16'd9, 16'd1, 16'd1}) begin errors++; $display("FAIL en_pkt got %0d/%0d/%0d want 9/1/1", pkt1, pkt2, pkt3); end
    checks++; if ({err1, err2, err3} !== {16'd3, 16'd0, 16'd0}) begin errors++; $display("FAIL en_err got %0d/%0d/%0d want 3/0/0", err1, err2, err3); end
  endtask

  task automatic test_saturation_reset();
    for (int i = 0; i < 3; i++) dat[i] = hdr(0);
    val = 3'b111;
    repeat (65539) tick();
    val = 3'b000; tick(); tick();
    checks++; if ({err1, err2, err3} !== {3{16'hFFFF}}) begin errors++; $display("FAIL sat_err got %h/%h/%h want ffff", err1, err2, err3); end
    checks++; if ({pkt1, pkt2, pkt3} !== {16'd12, 16'd4, 16'd4}) begin errors++; $display("FAIL wrap_pkt got %0d/%0d/%0d want 12/4/4", pkt1, pkt2, pkt3); end
    checks++; if (first !== 64'd3) begin errors++; $display("FAIL sat_first got %h want 3", first); end
    march = 1'b0;
    send(0, hdr(3)); send(0, sp(20));
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if ({pkt1, err1, pkt2, err2, pkt3, err3} !== 96'd0) begin errors++; $display("FAIL rst_cnt got %h want 0", {pkt1, err1, pkt2, err2, pkt3, err3}); end
    checks++; if (fail !== 1'b0 || first !== 64'd0 || rdy1 !== 1'b0) begin errors++; $display("FAIL rst_flags got %b/%h/%b want 0/0/0", fail, first, rdy1); end
    tick();
    send(0, hdr(1)); send(0, sp(0)); tick(); tick();
    checks++; if (pkt1 !== 16'd1 || err1 !== 16'd0 || fail !== 1'b0) begin errors++; $display("FAIL fresh got %0d/%0d/%b want 1/0/0", pkt1, err1, fail); end
    dat[1] = 64'h2222_0000_0000_0002; dat[2] = 64'h3333_0000_0000_0003; val = 3'b110; tick();
    val = 3'b000; tick();
    checks++; if ({err1, err2, err3} !== {16'd0, 16'd1, 16'd1} || fail !== 1'b1) begin errors++; $display("FAIL simul_err got %0d/%0d/%0d/%b want 0/1/1/1", err1, err2, err3, fail); end
    checks++; if (first !== 64'h2222_0000_0000_0002) begin errors++; $display("FAIL simul_first got %h want 2222000000000002", first); end
  endtask

  initial begin
    val = 3'b000;
    for (int i = 0; i < 3; i++) dat[i] = '0;
    test_reset();
    test_sequence();
    test_march();
    test_bad_header();
    test_enable();
    test_saturation_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/polara_loopback_packet_checker.md
Name: polara_loopback_packet_checker

Overview:
- Downstream consumer of the loopback packet generator: receives packets the chip returns on NoC1/2/3 (intf_chipset_* side) and checks each header and payload flit against the generator's deterministic pattern.
- Keeps per-NoC packet and error counters and a sticky fail flag for LEDs/debug.
- Sits in the chipset clock domain beside the generator, inside the polara loopback wrapper.

Parameters:
- MAX_PAYLOAD, 8, largest legal header payload-length field; 0 or larger is a header error.
- CNT_W, 16, width of the packet and error counters.

Ports:
- chipset_clk  in  1  clock
- chip_rst  in  1  reset; synchronous, active-high
- sw_debounced  in  2  channel enable: 00 none, 01 NoC1, 10 NoC2, 11 all three
- march  in  1  payload pattern select: 1 = walking-one, 0 = sequence
- intf_chipset_data_noc1/2/3  in  64 each  returned flit
- intf_chipset_val_noc1/2/3  in  1 each  flit valid
- intf_chipset_rdy_noc1/2/3  out  1 each  checker ready
- pkt_cnt_noc1/2/3  out  CNT_W each  completed packets; wraps
- err_cnt_noc1/2/3  out  CNT_W each  mismatching flits; saturates at all-ones
- check_fail  out  1  sticky OR of all errors
- first_err_data  out  64  data of the first erroneous flit since reset

Behaviour:
- Reset (chip_rst=1 at a chipset_clk edge) sets these to 0: all outputs, all FSMs (HDR), sequence counters and flit indices. Reset applied mid-packet abandons that packet with no error.
- Handshake: a flit is accepted when val && rdy on the same edge.
  - rdy_nocN = channel enabled && !chip_rst, registered, so it follows sw_debounced one cycle late.
  - A disabled channel holds all its state and counters; val is ignored.
- Per-channel FSM:
  - HDR:
    - On accept, len = data[29:22] and packet mode pm = march are latched; pm holds for the whole packet.
    - If 1 <= len <= MAX_PAYLOAD: flit index k = 0 and go to PLD.
    - Otherwise: header error, packet counted complete, stay in HDR.
  - PLD:
    - Each accepted flit is compared with the expected value, then k increments.
    - When k == len-1 is accepted: pkt_cnt increments and go to HDR.
- Expected payload:
  - pm=1: 64'h1 << (k mod 64).
  - pm=0: {seq, ~seq}. seq is a 32-bit per-channel counter that increments on every accepted payload flit, wraps 0xFFFFFFFF->0, and is not cleared between packets.
- Header check: only the length field is checked; the other header bits are don't-care.
- Errors are registered one cycle after the offending accept:
  - err_cnt increments and saturates at all-ones;
  - check_fail sets and is sticky until reset;
  - first_err_data is captured only while check_fail=0.
- Simultaneous errors on several channels in one cycle:
  - each channel's err_cnt increments;
  - first_err_data takes the lowest-numbered NoC.
- pkt_cnt updates on the edge of the last flit's accept.
- Backpressure: val with rdy=0 has no effect; flits may arrive with arbitrary idle gaps.

Decomposition:
- Package polara_loopback_pkg holds:
  - header field positions (LEN_HI=29, LEN_LO=22);
  - the enable encoding;
  - FSM state constants HDR/PLD;
  - pattern functions walk_pattern(k) and seq_pattern(seq), shared with the generator so both ends agree.
- One sub-module, polara_loopback_chan_checker (FSM, seq, counters, error pulse), instantiated three times.
- The top level adds the enable decode, rdy registers, check_fail and first_err_data priority.

Test Plan:
- Reset hold: chip_rst=1 for 3 cycles with val=1 on all NoCs -> all outputs 0 and rdy=0; rdy_noc1=1 one cycle after release with sw_debounced=01.
- Sequence mode: NoC1 header len=2, then payloads {0,~0}, {1,~1} -> pkt_cnt_noc1=1, err_cnt=0; the next packet expects seq=2.
- March mode: len=3 with payloads 1, 2, 4 -> pass; payload 3 in place of 4 -> err_cnt_noc1=1, check_fail=1 next cycle, first_err_data=3.
- Bad header: len=0 and then len=9 -> err_cnt=2, pkt_cnt=2, FSM stays in HDR; the next valid packet passes.
- Enable/backpressure: sw_debounced=01 with val on NoC2 -> rdy_noc2=0 and counters 0; switch to 11 mid-NoC1-packet -> NoC1 completes correctly and NoC2/3 start accepting one cycle later.
- Saturation and reset: force 2^CNT_W+3 errors -> err_cnt holds 16'hFFFF; chip_rst mid-packet -> everything clears and a fresh packet passes.
